// File: rtl/ex_wb_stage_pkg.sv
// ex_wb_stage_pkg: opcode encodings, buffer state codes and opcode-class helpers.
// Rev 1.0
`default_nettype none

package ex_wb_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 6;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_INC = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b0110;
  localparam logic [3:0] OP_SUB = 4'b0111;
  localparam logic [3:0] OP_J   = 4'b1000;
  localparam logic [3:0] OP_BRZ = 4'b1001;
  localparam logic [3:0] OP_BRN = 4'b1011;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_ONE   = 2'b01,
    BUF_TWO   = 2'b10
  } buf_state_e;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC) || (op == OP_NOT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_skid_buf.sv
// wb_skid_buf: two-entry FIFO of {rd,data} writebacks with flush and registered ready.
// Rev 1.0
`default_nettype none

module wb_skid_buf
  import ex_wb_stage_pkg::*;
#(
  parameter int ENTRY_W = 38
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic               i_flush,
  input  logic [ENTRY_W-1:0] i_din,
  output logic [ENTRY_W-1:0] o_head,
  output logic               o_valid,
  output logic               o_ready
);

  buf_state_e         r_state;
  buf_state_e         w_state_nxt;
  logic               r_ready;
  logic [ENTRY_W-1:0] r_head;
  logic [ENTRY_W-1:0] r_tail;
  logic               w_push;
  logic               w_pop;

  assign w_push = i_push & r_ready;
  assign w_pop  = i_pop & (r_state != BUF_EMPTY);

  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = BUF_EMPTY;
    end else begin
      case (r_state)
        BUF_EMPTY: if (w_push) w_state_nxt = BUF_ONE;
        BUF_ONE: begin
          if (w_push && !w_pop)      w_state_nxt = BUF_TWO;
          else if (!w_push && w_pop) w_state_nxt = BUF_EMPTY;
        end
        BUF_TWO:   if (w_pop) w_state_nxt = BUF_ONE;
        default:   w_state_nxt = BUF_EMPTY;
      endcase
    end
  end

  // Ready is registered from the next state so it never depends on i_pop combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BUF_EMPTY;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt != BUF_TWO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (!i_flush) begin
      case (r_state)
        BUF_EMPTY: if (w_push) r_head <= i_din;
        BUF_ONE: begin
          if (w_push && w_pop) r_head <= i_din;
          else if (w_push)     r_tail <= i_din;
        end
        BUF_TWO:   if (w_pop) r_head <= r_tail;
        default:   r_head <= r_head;
      endcase
    end
  end

  assign o_head  = r_head;
  assign o_valid = (r_state != BUF_EMPTY);
  assign o_ready = r_ready;

endmodule

`default_nettype wire

// File: rtl/ex_wb_stage.sv
// ex_wb_stage: post-ALU stage with Z/N flag register, branch resolve and buffered writeback.
// Rev 1.0
`default_nettype none

module ex_wb_stage
  import ex_wb_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [DATA_W-1:0] in_result,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [DATA_W-1:0] in_target,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_we,
  output logic [REG_W-1:0]  out_rd,
  output logic [DATA_W-1:0] out_wdata,
  output logic              flag_z,
  output logic              flag_n,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target
);

  logic                    w_accept;
  logic                    w_is_alu;
  logic                    w_br_hit;
  logic                    w_push;
  logic                    w_pop;
  logic [REG_W+DATA_W-1:0] w_head;
  logic                    r_flag_z;
  logic                    r_flag_n;
  logic                    r_br_taken;
  logic [DATA_W-1:0]       r_br_target;

  assign w_accept = in_valid & in_ready;
  assign w_is_alu = is_alu_op(in_opcode);
  // Conditional branches see the flags as committed before this edge.
  assign w_br_hit = (in_opcode == OP_J)
                  | ((in_opcode == OP_BRZ) & r_flag_z)
                  | ((in_opcode == OP_BRN) & r_flag_n);
  assign w_push   = w_accept & w_is_alu & ~flush;
  assign w_pop    = out_valid & out_ready;

  wb_skid_buf #(
    .ENTRY_W (REG_W + DATA_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (flush),
    .i_din   ({in_rd, in_result}),
    .o_head  (w_head),
    .o_valid (out_valid),
    .o_ready (in_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
    end else if (w_accept && w_is_alu) begin
      r_flag_z <= (in_result == '0);
      r_flag_n <= in_result[DATA_W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_taken  <= 1'b0;
      r_br_target <= '0;
    end else begin
      r_br_taken <= w_accept & w_br_hit;
      if (w_accept && w_br_hit) r_br_target <= in_target;
    end
  end

  assign out_we    = out_valid;
  assign out_rd    = w_head[REG_W+DATA_W-1:DATA_W];
  assign out_wdata = w_head[DATA_W-1:0];
  assign flag_z    = r_flag_z;
  assign flag_n    = r_flag_n;
  assign br_taken  = r_br_taken;
  assign br_target = r_br_target;

endmodule

`default_nettype wire

// File: tb/tb_ex_wb_stage.sv
// tb_ex_wb_stage: scoreboard bench for ex_wb_stage (writeback order, flags, branch pulses).
// Rev 1.0
`default_nettype none

module tb_ex_wb_stage;

  localparam int DW = 32;
  localparam int RW = 6;

  localparam logic [3:0] T_ADD = 4'b0001;
  localparam logic [3:0] T_SUB = 4'b0111;
  localparam logic [3:0] T_INC = 4'b0101;
  localparam logic [3:0] T_NOT = 4'b0110;
  localparam logic [3:0] T_J   = 4'b1000;
  localparam logic [3:0] T_BRZ = 4'b1001;
  localparam logic [3:0] T_BRN = 4'b1011;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_opcode;
  logic [DW-1:0] in_result;
  logic [RW-1:0] in_rd;
  logic [DW-1:0] in_target;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic          out_we;
  logic [RW-1:0] out_rd;
  logic [DW-1:0] out_wdata;
  logic          flag_z;
  logic          flag_n;
  logic          br_taken;
  logic [DW-1:0] br_target;

  always #5 clk = ~clk;

  ex_wb_stage #(.DATA_W(DW), .REG_W(RW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_result (in_result),
    .in_rd     (in_rd),
    .in_target (in_target),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_we    (out_we),
    .out_rd    (out_rd),
    .out_wdata (out_wdata),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .br_taken  (br_taken),
    .br_target (br_target)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
  } wb_t;

  wb_t           sb_q[$];
  logic          m_z = 1'b0;
  logic          m_n = 1'b0;
  logic          m_br = 1'b0;
  logic [DW-1:0] m_tgt = '0;

  task automatic check_val(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic tb_is_alu(input logic [3:0] op);
    return (op == T_ADD) || (op == T_SUB) || (op == T_INC) || (op == T_NOT);
  endfunction

  // One clock cycle: called at negedge, checks current outputs, drives, advances to next negedge.
  task automatic step(input logic v, input logic [3:0] op, input logic [DW-1:0] res,
                      input logic [RW-1:0] rd, input logic [DW-1:0] tgt,
                      input logic ordy, input logic fl, output logic acc);
    logic exp_ready;
    logic taken;
    in_valid  = v;
    in_opcode = op;
    in_result = res;
    in_rd     = rd;
    in_target = tgt;
    out_ready = ordy;
    flush     = fl;
    exp_ready = (sb_q.size() < 2);
    check_val("in_ready", in_ready, exp_ready);
    check_val("out_valid", out_valid, sb_q.size() != 0);
    check_val("out_we", out_we, sb_q.size() != 0);
    if (sb_q.size() != 0) begin
      check_val("out_rd", out_rd, sb_q[0].rd);
      check_val("out_wdata", out_wdata, sb_q[0].data);
    end
    acc   = v & exp_ready;
    taken = acc && ((op == T_J) || (op == T_BRZ && m_z) || (op == T_BRN && m_n));
    if (fl) sb_q.delete();
    else begin
      if (sb_q.size() != 0 && ordy) void'(sb_q.pop_front());
      if (acc && tb_is_alu(op)) sb_q.push_back('{rd: rd, data: res});
    end
    if (acc && tb_is_alu(op)) begin
      m_z = (res == '0);
      m_n = res[DW-1];
    end
    m_br = taken;
    if (taken) m_tgt = tgt;
    @(posedge clk);
    @(negedge clk);
    check_val("br_taken", br_taken, m_br);
    if (m_br) check_val("br_target", br_target, m_tgt);
    check_val("flag_z", flag_z, m_z);
    check_val("flag_n", flag_n, m_n);
  endtask

  task automatic send(input logic [3:0] op, input logic [DW-1:0] res, input logic [RW-1:0] rd,
                      input logic [DW-1:0] tgt, input logic ordy);
    logic acc;
    int   k;
    k = 0;
    do begin
      step(1'b1, op, res, rd, tgt, ordy, 1'b0, acc);
      k++;
    end while (!acc && k < 20);
    if (!acc) check_val("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input logic ordy, input logic fl);
    logic acc;
    step(1'b0, 4'b0000, '0, '0, '0, ordy, fl, acc);
  endtask

  task automatic reset_model();
    sb_q.delete();
    m_z  = 1'b0;
    m_n  = 1'b0;
    m_br = 1'b0;
  endtask

  initial begin
    logic acc;
    rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_result = '0; in_rd = '0;
    in_target = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_in_ready", in_ready, 1'b1);
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_out_we", out_we, 1'b0);
    check_val("rst_br_taken", br_taken, 1'b0);
    check_val("rst_flags", {flag_z, flag_n}, 2'b00);
    check_val("rst_out_rd", out_rd, '0);
    check_val("rst_out_wdata", out_wdata, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD result 0 to r3, then observed next cycle
    send(T_ADD, 32'h0, 6'd3, '0, 1'b1);
    idle(1'b1, 1'b0);

    // SUB negative, BRN taken, BRZ not taken, back-to-back J pulses
    send(T_SUB, 32'hFFFF_FFFE, 6'd4, '0, 1'b1);
    send(T_BRN, 32'h0, 6'd0, 32'h40, 1'b1);
    idle(1'b1, 1'b0);
    send(T_BRZ, 32'h0, 6'd0, 32'h80, 1'b1);
    send(T_J, 32'h0, 6'd0, 32'h100, 1'b1);
    send(T_J, 32'h0, 6'd0, 32'h104, 1'b1);
    send(4'b0011, 32'h0, 6'd9, 32'h200, 1'b1);
    idle(1'b1, 1'b0);

    // Stall with out_ready low; third op held until a pop frees a slot
    send(T_ADD, 32'h11, 6'd1, '0, 1'b0);
    send(T_INC, 32'h22, 6'd2, '0, 1'b0);
    step(1'b1, T_NOT, 32'h33, 6'd3, '0, 1'b0, 1'b0, acc);
    check_val("held_while_two", acc, 1'b0);
    step(1'b1, T_NOT, 32'h33, 6'd3, '0, 1'b1, 1'b0, acc);
    check_val("pop_refuses_push", acc, 1'b0);
    step(1'b1, T_NOT, 32'h33, 6'd3, '0, 1'b1, 1'b0, acc);
    check_val("push_after_pop", acc, 1'b1);
    repeat (3) idle(1'b1, 1'b0);

    // Flush with an accepted INC: flags update, nothing pushed
    send(T_ADD, 32'h5, 6'd5, '0, 1'b0);
    step(1'b1, T_INC, 32'h8000_0000, 6'd6, '0, 1'b0, 1'b1, acc);
    idle(1'b1, 1'b0);
    // Flush in TWO, and a branch accepted with flush still pulses
    send(T_ADD, 32'h7, 6'd7, '0, 1'b0);
    send(T_SUB, 32'h8, 6'd8, '0, 1'b0);
    idle(1'b0, 1'b1);
    step(1'b1, T_BRN, 32'h0, 6'd0, 32'h300, 1'b1, 1'b1, acc);
    idle(1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      logic [DW-1:0] r;
      r = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), r, 6'($urandom_range(0, 63)),
           DW'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, acc);
    end
    repeat (3) idle(1'b1, 1'b0);

    // Asynchronous reset mid-operation with a pending branch pulse
    send(T_SUB, 32'hFFFF_0000, 6'd10, '0, 1'b0);
    in_valid = 1'b1; in_opcode = T_J; in_target = 32'h500; flush = 1'b0;
    @(posedge clk);
    #2;
    check_val("pre_rst_br", br_taken, 1'b1);
    rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", out_valid, 1'b0);
    check_val("midrst_in_ready", in_ready, 1'b1);
    check_val("midrst_flags", {flag_z, flag_n}, 2'b00);
    check_val("midrst_br_taken", br_taken, 1'b0);
    reset_model();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(T_ADD, 32'h1234, 6'd12, '0, 1'b1);
    idle(1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
